// File: rtl/btb_pkg.sv
// Shared types for the btb resolve controller: in-flight prediction entry and FSM states.
package btb_pkg;

  localparam logic [31:0] INSTR_BYTES = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic        hit;
    logic        taken;
    logic [31:0] target;
  } pred_entry_t;

  typedef enum logic [0:0] {
    RUN,
    RECOVER
  } resolve_state_e;

endpackage

// File: rtl/pred_fifo.sv
// In-order queue of in-flight btb predictions; flush clears all entries and wins over push/pop.
module pred_fifo
  import btb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  pred_entry_t                entry_i,
  input  logic                       pop_i,
  output pred_entry_t                head_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  pred_entry_t         mem_q [DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]     count_q, count_d;
  logic                push_ok, pop_ok;

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so pointer overflow is the modulo wrap.
      if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d = count_q + CntW'(push_ok) - CntW'(pop_ok);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok && !flush_i) begin
      mem_q[wr_ptr_q] <= entry_i;
    end
  end

endmodule

// File: rtl/btb_resolve_ctrl.sv
// Resolves in-flight btb predictions against execute outcomes, trains the btb and redirects fetch.
// Optional perf counters enabled by defining BTB_RESOLVE_PERF_EN.
module btb_resolve_ctrl
  import btb_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned RECOVER_CYC = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_valid,
  output logic                     push_ready,
  input  logic [31:0]              push_pc,
  input  logic                     push_hit,
  input  logic                     push_taken,
  input  logic [31:0]              push_target,
  input  logic                     res_valid,
  input  logic                     res_taken,
  input  logic [31:0]              res_target,
  output logic                     update,
  output logic [31:0]              updatePC,
  output logic [31:0]              updateTarget,
  output logic                     mispredicted,
  output logic                     redirect_valid,
  output logic [31:0]              redirect_pc,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     res_err
`ifdef BTB_RESOLVE_PERF_EN
  ,
  output logic [31:0]              perf_resolved,
  output logic [31:0]              perf_mispred
`endif
);

  localparam int unsigned RcW = $clog2(RECOVER_CYC + 1);

  resolve_state_e state_q, state_d;
  logic [RcW-1:0] rcnt_q, rcnt_d;

  pred_entry_t push_entry, head;
  logic        fifo_full, fifo_empty;
  logic        push_fire, res_fire, pred_t, mispredict;

  logic        update_q, update_d;
  logic [31:0] update_pc_q, update_pc_d;
  logic [31:0] update_tgt_q, update_tgt_d;
  logic        mispred_q, mispred_d;
  logic        redir_valid_q, redir_valid_d;
  logic [31:0] redir_pc_q, redir_pc_d;
  logic        res_err_q, res_err_d;

  assign push_entry = '{pc: push_pc, hit: push_hit, taken: push_taken, target: push_target};

  // Full blocks pushes even when a pop lands in the same cycle.
  assign push_ready = rst && (state_q == RUN) && !fifo_full;
  assign push_fire  = push_valid && push_ready;
  assign res_fire   = res_valid && !fifo_empty;
  assign pred_t     = head.hit && head.taken;
  assign mispredict = res_fire &&
                      ((pred_t != res_taken) || (pred_t && res_taken && head.target != res_target));

  pred_fifo #(
    .DEPTH (DEPTH)
  ) u_pred_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .flush_i (mispredict),
    .push_i  (push_fire && !mispredict),
    .entry_i (push_entry),
    .pop_i   (res_fire),
    .head_o  (head),
    .count_o (occupancy),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    unique case (state_q)
      RUN: begin
        if (mispredict) begin
          state_d = RECOVER;
          rcnt_d  = RcW'(RECOVER_CYC);
        end
      end
      RECOVER: begin
        if (rcnt_q <= RcW'(1)) begin
          state_d = RUN;
          rcnt_d  = '0;
        end else begin
          rcnt_d = rcnt_q - RcW'(1);
        end
      end
      default: begin
        state_d = RUN;
        rcnt_d  = '0;
      end
    endcase
  end

  always_comb begin
    update_d      = res_fire && (res_taken || head.hit);
    update_pc_d   = update_d ? head.pc : '0;
    update_tgt_d  = update_d ? (res_taken ? res_target : head.target) : '0;
    mispred_d     = mispredict;
    redir_valid_d = mispredict;
    redir_pc_d    = mispredict ? (res_taken ? res_target : head.pc + INSTR_BYTES) : '0;
    res_err_d     = res_err_q || (res_valid && fifo_empty);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= RUN;
      rcnt_q        <= '0;
      update_q      <= 1'b0;
      update_pc_q   <= '0;
      update_tgt_q  <= '0;
      mispred_q     <= 1'b0;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= '0;
      res_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      rcnt_q        <= rcnt_d;
      update_q      <= update_d;
      update_pc_q   <= update_pc_d;
      update_tgt_q  <= update_tgt_d;
      mispred_q     <= mispred_d;
      redir_valid_q <= redir_valid_d;
      redir_pc_q    <= redir_pc_d;
      res_err_q     <= res_err_d;
    end
  end

  assign update         = update_q;
  assign updatePC       = update_pc_q;
  assign updateTarget   = update_tgt_q;
  assign mispredicted   = mispred_q;
  assign redirect_valid = redir_valid_q;
  assign redirect_pc    = redir_pc_q;
  assign res_err        = res_err_q;

`ifdef BTB_RESOLVE_PERF_EN
  logic [31:0] perf_resolved_q, perf_mispred_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_resolved_q <= '0;
      perf_mispred_q  <= '0;
    end else begin
      if (res_fire && perf_resolved_q != '1) perf_resolved_q <= perf_resolved_q + 32'd1;
      if (mispredict && perf_mispred_q != '1) perf_mispred_q <= perf_mispred_q + 32'd1;
    end
  end

  assign perf_resolved = perf_resolved_q;
  assign perf_mispred  = perf_mispred_q;
`else
  // Default build carries no performance counters.
`endif

endmodule
